// File: rtl/uart_tx.sv
// UART transmitter: valid/ready byte input, one-entry holding register, 8-bit frames on TX
// with optional even/odd parity and one or two stop bits.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | line idle high, waiting for the holding register to fill
// S_START  | driving the start bit (low)
// S_DATA   | driving D0..D7, LSB first
// S_PARITY | driving the parity bit (only when PARITY != 0)
// S_STOP   | driving STOP_BITS stop bits (high)
module uart_tx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [7:0] DATA_IN,
   input  logic       DATA_VALID,
   output logic       DATA_READY,
   output logic       TX,
   output logic       BUSY
);

   localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic          PAR_ODD   = (PARITY == 2);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t        state_q, state_nxt;
   logic [CW-1:0] baud_q, baud_nxt;
   logic [2:0]    bit_q, bit_nxt;
   logic [7:0]    shift_q, shift_nxt;
   logic [7:0]    hold_q, hold_nxt;
   logic          hold_full_q, hold_full_nxt;
   logic          ready_q, ready_nxt;
   logic          tx_q, tx_nxt;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= S_IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         ready_q     <= 1'b1;
         tx_q        <= 1'b1;
      end else begin
         state_q     <= state_nxt;
         baud_q      <= baud_nxt;
         bit_q       <= bit_nxt;
         shift_q     <= shift_nxt;
         hold_q      <= hold_nxt;
         hold_full_q <= hold_full_nxt;
         ready_q     <= ready_nxt;
         tx_q        <= tx_nxt;
      end
   end

   always_comb begin
      state_nxt     = state_q;
      baud_nxt      = baud_q;
      bit_nxt       = bit_q;
      shift_nxt     = shift_q;
      hold_nxt      = hold_q;
      hold_full_nxt = hold_full_q;
      tx_nxt        = tx_q;

      // ready_q is low whenever the holding register is full, so an accept never
      // coincides with a transfer out of the holding register below.
      if (DATA_VALID && ready_q) begin
         hold_nxt      = DATA_IN;
         hold_full_nxt = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (hold_full_q) begin
               state_nxt     = S_START;
               shift_nxt     = hold_q;
               hold_full_nxt = 1'b0;
               baud_nxt      = '0;
               tx_nxt        = 1'b0;
            end
         end
         S_START: begin
            if (baud_q == BAUD_MAX) begin
               state_nxt = S_DATA;
               baud_nxt  = '0;
               bit_nxt   = '0;
               tx_nxt    = shift_q[0];
            end else begin
               baud_nxt = baud_q + 1'b1;
            end
         end
         S_DATA: begin
            if (baud_q == BAUD_MAX) begin
               baud_nxt = '0;
               if (bit_q == 3'd7) begin
                  bit_nxt = '0;
                  if (PARITY != 0) begin
                     state_nxt = S_PARITY;
                     tx_nxt    = (^shift_q) ^ PAR_ODD;
                  end else begin
                     state_nxt = S_STOP;
                     tx_nxt    = 1'b1;
                  end
               end else begin
                  bit_nxt = bit_q + 3'd1;
                  tx_nxt  = shift_q[bit_q + 3'd1];
               end
            end else begin
               baud_nxt = baud_q + 1'b1;
            end
         end
         S_PARITY: begin
            if (baud_q == BAUD_MAX) begin
               state_nxt = S_STOP;
               baud_nxt  = '0;
               bit_nxt   = '0;
               tx_nxt    = 1'b1;
            end else begin
               baud_nxt = baud_q + 1'b1;
            end
         end
         S_STOP: begin
            if (baud_q == BAUD_MAX) begin
               baud_nxt = '0;
               if (bit_q == STOP_LAST) begin
                  bit_nxt = '0;
                  if (hold_full_q) begin
                     state_nxt     = S_START;
                     shift_nxt     = hold_q;
                     hold_full_nxt = 1'b0;
                     tx_nxt        = 1'b0;
                  end else begin
                     state_nxt = S_IDLE;
                  end
               end else begin
                  bit_nxt = bit_q + 3'd1;
               end
            end else begin
               baud_nxt = baud_q + 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            tx_nxt    = 1'b1;
         end
      endcase

      ready_nxt = !hold_full_nxt;
   end

   assign DATA_READY = ready_q;
   assign TX         = tx_q;
   assign BUSY       = (state_q != S_IDLE) || hold_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4: four instances cover no parity, even,
// odd and two stop bits; frames are checked bit by bit against hand-built patterns.
module tb_uart_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid [4];
   logic [7:0] din   [4];
   logic       ready [4];
   logic       tx    [4];
   logic       busy  [4];
   int         cyc = 0;
   int         vec_cnt = 0;
   int         miss_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
      .CLK(clk), .RESET_N(rst_n), .DATA_IN(din[0]), .DATA_VALID(valid[0]),
      .DATA_READY(ready[0]), .TX(tx[0]), .BUSY(busy[0]));
   uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) dut1 (
      .CLK(clk), .RESET_N(rst_n), .DATA_IN(din[1]), .DATA_VALID(valid[1]),
      .DATA_READY(ready[1]), .TX(tx[1]), .BUSY(busy[1]));
   uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) dut2 (
      .CLK(clk), .RESET_N(rst_n), .DATA_IN(din[2]), .DATA_VALID(valid[2]),
      .DATA_READY(ready[2]), .TX(tx[2]), .BUSY(busy[2]));
   uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) dut3 (
      .CLK(clk), .RESET_N(rst_n), .DATA_IN(din[3]), .DATA_VALID(valid[3]),
      .DATA_READY(ready[3]), .TX(tx[3]), .BUSY(busy[3]));

   // frame bit i is the i-th bit on the line: start, D0..D7, [parity], stop(s)
   typedef struct {
      int          d;
      logic [7:0]  data;
      logic [11:0] frame;
      int          nbits;
   } vec_t;

   vec_t tbl [8];

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Called on the negedge after the start-bit edge; returns on the negedge after the
   // last frame cycle. Each bit is sampled on its first and last cycle.
   task automatic check_frame(input int d, input logic [11:0] fr, input int n, input string nm);
      logic t0, t1, b0, b1;
      for (int i = 0; i < n; i++) begin
         t0 = tx[d];
         b0 = busy[d];
         step(CPB - 1);
         t1 = tx[d];
         b1 = busy[d];
         chk($sformatf("%s_bit%0d", nm, i), 32'({t0, t1, b0, b1}),
             32'({fr[i], fr[i], 1'b1, 1'b1}));
         step(1);
      end
   endtask

   task automatic wait_ready(input int d, input string nm);
      int t;
      t = 0;
      while (ready[d] !== 1'b1 && t < 200) begin
         step(1);
         t++;
      end
      chk({nm, "_ready_wait"}, 32'(ready[d]), 32'(1));
   endtask

   task automatic send_single(input int d, input logic [7:0] data, input logic [11:0] fr,
                              input int n, input string nm);
      wait_ready(d, nm);
      din[d]   = data;
      valid[d] = 1'b1;
      step(1);
      chk({nm, "_accept"}, 32'({ready[d], busy[d], tx[d]}), 32'(3'b011));
      valid[d] = 1'b0;
      din[d]   = ~data;
      step(1);
      chk({nm, "_start"}, 32'({ready[d], busy[d], tx[d]}), 32'(3'b110));
      check_frame(d, fr, n, nm);
      chk({nm, "_end"}, 32'({ready[d], busy[d], tx[d]}), 32'(3'b101));
   endtask

   initial begin
      int acc [3];
      int bad;

      tbl[0] = '{d: 0, data: 8'h55, frame: 12'h2AA, nbits: 10};
      tbl[1] = '{d: 0, data: 8'h80, frame: 12'h300, nbits: 10};
      tbl[2] = '{d: 1, data: 8'h07, frame: 12'h60E, nbits: 11};
      tbl[3] = '{d: 2, data: 8'h07, frame: 12'h40E, nbits: 11};
      tbl[4] = '{d: 1, data: 8'h00, frame: 12'h400, nbits: 11};
      tbl[5] = '{d: 2, data: 8'h00, frame: 12'h600, nbits: 11};
      tbl[6] = '{d: 3, data: 8'hFF, frame: 12'h7FE, nbits: 11};
      tbl[7] = '{d: 3, data: 8'h00, frame: 12'h600, nbits: 11};

      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         valid[i] = 1'b0;
         din[i]   = 8'h00;
      end
      step(3);
      for (int i = 0; i < 4; i++)
         chk($sformatf("reset_in_%0d", i), 32'({ready[i], busy[i], tx[i]}), 32'(3'b101));
      rst_n = 1'b1;
      step(3);
      for (int i = 0; i < 4; i++)
         chk($sformatf("reset_out_%0d", i), 32'({ready[i], busy[i], tx[i]}), 32'(3'b101));

      for (int v = 0; v < 8; v++)
         send_single(tbl[v].d, tbl[v].data, tbl[v].frame, tbl[v].nbits, $sformatf("vec%0d", v));

      // back-to-back: 0x3C queued during the 0xA5 frame, no idle cycle between frames
      wait_ready(0, "b2b");
      din[0]   = 8'hA5;
      valid[0] = 1'b1;
      step(1);
      valid[0] = 1'b0;
      step(1);
      chk("b2b_ready_after_xfer", 32'(ready[0]), 32'(1));
      fork
         begin
            check_frame(0, 12'h34A, 10, "b2b_a5");
            check_frame(0, 12'h278, 10, "b2b_3c");
         end
         begin
            din[0]   = 8'h3C;
            valid[0] = 1'b1;
            step(1);
            chk("b2b_accept", 32'(ready[0]), 32'(0));
            valid[0] = 1'b0;
            din[0]   = 8'hFF;
            bad      = 0;
            for (int i = 0; i < 38; i++) begin
               step(1);
               if (ready[0] !== 1'b0) bad++;
            end
            chk("b2b_ready_low", 32'(bad), 32'(0));
            step(1);
            chk("b2b_ready_back", 32'(ready[0]), 32'(1));
         end
      join
      chk("b2b_idle", 32'({ready[0], busy[0], tx[0]}), 32'(3'b101));

      // backpressure: DATA_VALID held high across three bytes
      wait_ready(0, "bp1");
      din[0]   = 8'h01;
      valid[0] = 1'b1;
      step(1);
      acc[0] = cyc;
      fork
         begin
            step(1);
            check_frame(0, 12'h202, 10, "bp_01");
            check_frame(0, 12'h204, 10, "bp_02");
            check_frame(0, 12'h206, 10, "bp_03");
         end
         begin
            wait_ready(0, "bp2");
            din[0] = 8'h02;
            step(1);
            acc[1] = cyc;
            wait_ready(0, "bp3");
            din[0] = 8'h03;
            step(1);
            acc[2] = cyc;
            valid[0] = 1'b0;
         end
      join
      chk("bp_accept2_delay", 32'(acc[1] - acc[0]), 32'(2));
      chk("bp_accept3_delay", 32'(acc[2] - acc[0]), 32'(2 + 10 * CPB));
      chk("bp_idle", 32'({ready[0], busy[0], tx[0]}), 32'(3'b101));

      // reset during D3 of 0x00 with 0x5A queued
      wait_ready(0, "rst");
      din[0]   = 8'h00;
      valid[0] = 1'b1;
      step(1);
      valid[0] = 1'b0;
      step(1);
      din[0]   = 8'h5A;
      valid[0] = 1'b1;
      step(1);
      valid[0] = 1'b0;
      chk("rst_queued", 32'({ready[0], busy[0]}), 32'(2'b01));
      step(4 * CPB);
      chk("rst_in_d3", 32'(tx[0]), 32'(0));
      rst_n = 1'b0;
      #1;
      chk("rst_async", 32'({ready[0], busy[0], tx[0]}), 32'(3'b101));
      step(2);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         step(1);
         if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b1) bad++;
      end
      chk("rst_quiet", 32'(bad), 32'(0));
      send_single(0, 8'hC3, 12'h386, 10, "rst_recover");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the FPGA test harness: the host-bound half of the UART link, converting bytes offered on a valid/ready interface into 8-bit asynchronous frames on `TX`. It replaces the current RX-to-TX loopback, so captured project outputs and scan status can be reported back to the host. A one-entry holding register lets the producer queue the next byte while the current frame shifts, giving gap-free back-to-back frames.

## Interface
- `CLKS_PER_BIT`, 104 — clock cycles per bit (12 MHz / 115200); legal range 2..65535.
- `PARITY`, 0 — 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1 — 1 or 2.

Ports:
- `CLK`  input  1  — system clock; all logic on rising edge.
- `RESET_N`  input  1  — asynchronous, active-low reset.
- `DATA_IN`  input  8  — byte to send; sampled on the accept edge.
- `DATA_VALID`  input  1  — producer offers `DATA_IN`.
- `DATA_READY`  output  1  — holding register empty; byte accepted on any edge where `DATA_VALID & DATA_READY`.
- `TX`  output  1  — serial line; idle high; driven from a flop.
- `BUSY`  output  1  — frame in progress or byte pending in the holding register.

## Operation
- Reset values, applied asynchronously while `RESET_N` is low:
  - `TX`=1, `DATA_READY`=1, `BUSY`=0.
  - Holding register empty; shifter IDLE; bit counter and baud counter 0.
- Holding register:
  - Accept sets it full and clears `DATA_READY` from the next cycle.
  - `DATA_IN` is not resampled until the holding register empties again.
- Shifter FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the holding register is full: byte moves to the shift register, holding register empties, `TX`<=0.
  - START → DATA after `CLKS_PER_BIT` cycles; D0 first (LSB first), one bit per `CLKS_PER_BIT` cycles, 8 bits.
  - DATA → PARITY if `PARITY`≠0, otherwise → STOP.
  - PARITY bit: even = XOR of the 8 data bits; odd = inverted XOR.
  - STOP drives `TX`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles.
  - At the end of STOP: go to START directly if the holding register is full (no idle bit); otherwise → IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1, resets to 0 on every bit boundary and on entry to START. Width = clog2(`CLKS_PER_BIT`).
- `DATA_READY` = NOT holding-full, registered. The producer can therefore queue exactly one byte during a frame.
- `BUSY` = (state≠IDLE) OR holding-full.
- Simultaneous accept and holding→shifter transfer cannot occur: `DATA_READY` is low whenever the holding register is full.
- `DATA_VALID` deasserted without an accept: no effect. `DATA_IN` changing while not accepted: ignored.
- Reset mid-frame:
  - `TX` returns high immediately and the frame is truncated.
  - Both the pending byte and the shifting byte are discarded.

## Timing
- Accept at edge k with the shifter idle:
  - Holding register full after edge k.
  - Start bit on `TX` after edge k+1; `DATA_READY` back high after edge k+1.
- Start bit occupies edges k+1 .. k+1+`CLKS_PER_BIT`. Bit n (D0=0) begins `CLKS_PER_BIT`×(n+1) cycles after the start bit begins.
- Frame length in cycles: `CLKS_PER_BIT`×(1+8+(`PARITY`≠0)+`STOP_BITS`). With defaults: 1040 cycles.
- Back-to-back: if a byte is queued before the final stop bit ends, the next start bit begins on the cycle after the last stop cycle. Sustained throughput is exactly one frame per frame length.
- `BUSY` falls the cycle after the last stop cycle when nothing is queued.
- The `TX` glitch-free requirement holds: `TX` is the only output of the serial path and comes straight from a flop.

## Test plan
- Single byte, `CLKS_PER_BIT`=4, no parity, 1 stop, send 0x55 → `TX` = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. Start bit begins 2 edges after accept. `BUSY` is high for 40 cycles + 1.
- Back-to-back 0xA5 then 0x3C:
  - Second byte accepted during the first frame; `DATA_READY` low until the 0x3C transfer.
  - Second start bit immediately follows the first stop bit with zero idle cycles.
- Backpressure: hold `DATA_VALID` high with 0x01, 0x02, 0x03 → third byte accepted only after 0x02 moves to the shifter. Three frames appear in order.
- Parity, `PARITY`=1 then `PARITY`=2, send 0x07 → even-parity bit 1, odd-parity bit 0. 11-bit frame.
- `STOP_BITS`=2, send 0xFF → `TX` high for 2×`CLKS_PER_BIT` after D7 before the next queued start bit.
- Reset mid-frame: assert `RESET_N`=0 during D3 of 0x00 with a byte queued → `TX`=1 immediately, `DATA_READY`=1, `BUSY`=0. No frame is emitted after release until a new accept.
